// File: rtl/rv32i_types.sv
// Shared RV32I front-end types: BTB entry layout and predictor constants.
package rv32i_types;

  localparam logic [1:0] PHT_WEAK_NT   = 2'b01;
  localparam int         PC_ALIGN_BITS = 2;
  // Widest tag any BTB size can need; narrower tags are zero-extended.
  localparam int         BTB_TAG_W_MAX = 32 - PC_ALIGN_BITS;

  typedef struct packed {
    logic                     valid;
    logic [BTB_TAG_W_MAX-1:0] tag;
    logic [31:0]              target;
    logic                     is_jump;
  } btb_entry_t;

endpackage

// File: rtl/sat_counter2.sv
// Next-state function of a 2-bit saturating counter (0..3).
module sat_counter2 (
  input  logic [1:0] cnt_i,
  input  logic       taken_i,
  output logic [1:0] cnt_o
);

  always_comb begin
    cnt_o = cnt_i;
    if (taken_i) begin
      if (cnt_i != 2'b11) cnt_o = cnt_i + 2'b01;
    end else begin
      if (cnt_i != 2'b00) cnt_o = cnt_i - 2'b01;
    end
  end

endmodule

// File: rtl/branch_predictor.sv
// Gshare + direct-mapped BTB branch predictor with EX-side training,
// speculative global history repair and performance counters.
module branch_predictor
  import rv32i_types::*;
#(
  parameter int PHT_IDX_BITS = 7,
  parameter int BTB_IDX_BITS = 5
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [31:0]             fetch_pc,
  input  logic                    fetch_advance,
  output logic                    is_branch,
  output logic                    pht_prediction,
  output logic [31:0]             pc_taken,
  output logic [PHT_IDX_BITS-1:0] pred_ghr,
  input  logic                    upd_valid,
  input  logic                    upd_is_jump,
  input  logic [31:0]             upd_pc,
  input  logic                    upd_taken,
  input  logic [31:0]             upd_target,
  input  logic [PHT_IDX_BITS-1:0] upd_ghr,
  input  logic                    branch_recovery,
  input  logic                    perf_pred,
  input  logic                    perf_mispred,
  output logic [31:0]             perf_pred_count,
  output logic [31:0]             perf_mispred_count
);

  localparam int PHT_N = 2 ** PHT_IDX_BITS;
  localparam int BTB_N = 2 ** BTB_IDX_BITS;
  localparam int TAG_W = 32 - BTB_IDX_BITS - PC_ALIGN_BITS;

  logic [1:0]              pht_q [PHT_N];
  logic [1:0]              pht_d [PHT_N];
  btb_entry_t              btb_q [BTB_N];
  btb_entry_t              btb_d [BTB_N];
  logic [PHT_IDX_BITS-1:0] ghr_q, ghr_d;
  logic [31:0]             perf_pred_count_q, perf_pred_count_d;
  logic [31:0]             perf_mispred_count_q, perf_mispred_count_d;

  logic [BTB_IDX_BITS-1:0] fetch_btb_idx, upd_btb_idx;
  logic [PHT_IDX_BITS-1:0] fetch_pht_idx, upd_pht_idx;
  logic [TAG_W-1:0]        fetch_tag, upd_tag;
  btb_entry_t              fetch_entry;
  logic                    fetch_hit;
  logic                    fetch_ctr_taken;
  logic [1:0]              upd_ctr_next;
  logic                    unused_upd_pc_bits;

  assign unused_upd_pc_bits = ^upd_pc[PC_ALIGN_BITS-1:0];

  // Lookup path: fully combinational so IF gets a prediction in the same cycle.
  always_comb begin
    fetch_btb_idx   = fetch_pc[BTB_IDX_BITS+PC_ALIGN_BITS-1:PC_ALIGN_BITS];
    fetch_tag       = fetch_pc[31:BTB_IDX_BITS+PC_ALIGN_BITS];
    fetch_pht_idx   = fetch_pc[PHT_IDX_BITS+PC_ALIGN_BITS-1:PC_ALIGN_BITS] ^ ghr_q;
    fetch_entry     = btb_q[fetch_btb_idx];
    fetch_hit       = fetch_entry.valid && (fetch_entry.tag == BTB_TAG_W_MAX'(fetch_tag));
    fetch_ctr_taken = pht_q[fetch_pht_idx][1];
    is_branch       = fetch_hit;
    pht_prediction  = fetch_hit && (fetch_entry.is_jump || fetch_ctr_taken);
    pc_taken        = pht_prediction ? fetch_entry.target : fetch_pc + 32'd4;
    pred_ghr        = ghr_q;
  end

  assign upd_btb_idx = upd_pc[BTB_IDX_BITS+PC_ALIGN_BITS-1:PC_ALIGN_BITS];
  assign upd_tag     = upd_pc[31:BTB_IDX_BITS+PC_ALIGN_BITS];
  assign upd_pht_idx = upd_pc[PHT_IDX_BITS+PC_ALIGN_BITS-1:PC_ALIGN_BITS] ^ upd_ghr;

  sat_counter2 u_sat_counter2 (
    .cnt_i   (pht_q[upd_pht_idx]),
    .taken_i (upd_taken),
    .cnt_o   (upd_ctr_next)
  );

  // Training and history: recovery from EX overrides any speculative shift.
  always_comb begin
    pht_d                = pht_q;
    btb_d                = btb_q;
    ghr_d                = ghr_q;
    perf_pred_count_d    = perf_pred_count_q + {31'd0, perf_pred};
    perf_mispred_count_d = perf_mispred_count_q + {31'd0, perf_mispred};

    if (upd_valid && !upd_is_jump) pht_d[upd_pht_idx] = upd_ctr_next;
    if (upd_valid && upd_taken) begin
      btb_d[upd_btb_idx].valid   = 1'b1;
      btb_d[upd_btb_idx].tag     = BTB_TAG_W_MAX'(upd_tag);
      btb_d[upd_btb_idx].target  = upd_target;
      btb_d[upd_btb_idx].is_jump = upd_is_jump;
    end

    if (branch_recovery) begin
      ghr_d = upd_is_jump ? upd_ghr : {upd_ghr[PHT_IDX_BITS-2:0], upd_taken};
    end else if (fetch_advance && fetch_hit && !fetch_entry.is_jump) begin
      ghr_d = {ghr_q[PHT_IDX_BITS-2:0], fetch_ctr_taken};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < PHT_N; i++) pht_q[i] <= PHT_WEAK_NT;
      for (int i = 0; i < BTB_N; i++) btb_q[i] <= '0;
      ghr_q                <= '0;
      perf_pred_count_q    <= '0;
      perf_mispred_count_q <= '0;
    end else begin
      pht_q                <= pht_d;
      btb_q                <= btb_d;
      ghr_q                <= ghr_d;
      perf_pred_count_q    <= perf_pred_count_d;
      perf_mispred_count_q <= perf_mispred_count_d;
    end
  end

  assign perf_pred_count    = perf_pred_count_q;
  assign perf_mispred_count = perf_mispred_count_q;

endmodule

// File: tb/tb_branch_predictor.sv
// Directed self-checking bench for branch_predictor: lookup, training,
// saturation, jumps, history recovery, BTB conflicts, perf counters, reset.
module tb_branch_predictor;

  logic        clk;
  logic        rst_n;
  logic [31:0] fetch_pc;
  logic        fetch_advance;
  logic        is_branch;
  logic        pht_prediction;
  logic [31:0] pc_taken;
  logic [6:0]  pred_ghr;
  logic        upd_valid;
  logic        upd_is_jump;
  logic [31:0] upd_pc;
  logic        upd_taken;
  logic [31:0] upd_target;
  logic [6:0]  upd_ghr;
  logic        branch_recovery;
  logic        perf_pred;
  logic        perf_mispred;
  logic [31:0] perf_pred_count;
  logic [31:0] perf_mispred_count;

  int testsRun = 0;
  int testsFailed = 0;

  branch_predictor #(.PHT_IDX_BITS(7), .BTB_IDX_BITS(5)) dut (
    .clk                (clk),
    .rst_n              (rst_n),
    .fetch_pc           (fetch_pc),
    .fetch_advance      (fetch_advance),
    .is_branch          (is_branch),
    .pht_prediction     (pht_prediction),
    .pc_taken           (pc_taken),
    .pred_ghr           (pred_ghr),
    .upd_valid          (upd_valid),
    .upd_is_jump        (upd_is_jump),
    .upd_pc             (upd_pc),
    .upd_taken          (upd_taken),
    .upd_target         (upd_target),
    .upd_ghr            (upd_ghr),
    .branch_recovery    (branch_recovery),
    .perf_pred          (perf_pred),
    .perf_mispred       (perf_mispred),
    .perf_pred_count    (perf_pred_count),
    .perf_mispred_count (perf_mispred_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic v, input logic j, input logic [31:0] pc,
                               input logic t, input logic [31:0] tgt,
                               input logic [6:0] g, input logic rec);
    upd_valid       = v;
    upd_is_jump     = j;
    upd_pc          = pc;
    upd_taken       = t;
    upd_target      = tgt;
    upd_ghr         = g;
    branch_recovery = rec;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    testsRun++;
    assert (observed === expected)
    else begin
      testsFailed++;
      $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
    end
  endtask

  initial begin
    rst_n = 1'b0;
    fetch_pc = 32'h60;
    fetch_advance = 1'b0;
    perf_pred = 1'b0;
    perf_mispred = 1'b0;
    applyStimulus(0, 0, 0, 0, 0, 0, 0);
    #12;
    checkOutput("rst_is_branch", is_branch, 0);
    checkOutput("rst_pred", pht_prediction, 0);
    checkOutput("rst_pc_taken", pc_taken, 32'h64);
    checkOutput("rst_ghr", pred_ghr, 0);
    checkOutput("rst_perf_pred", perf_pred_count, 0);
    checkOutput("rst_perf_mispred", perf_mispred_count, 0);
    rst_n = 1'b1;
    tick();

    // First taken branch at 0x60: lookup in the same cycle sees the old (empty) BTB
    applyStimulus(1, 0, 32'h60, 1, 32'h100, 0, 0);
    #1;
    checkOutput("rbw_is_branch", is_branch, 0);
    tick();
    applyStimulus(0, 0, 0, 0, 0, 0, 0);
    #1;
    checkOutput("train_is_branch", is_branch, 1);
    checkOutput("train_ctr", dut.pht_q[24], 2);
    checkOutput("train_pred", pht_prediction, 1);
    checkOutput("train_pc_taken", pc_taken, 32'h100);

    // Not-taken updates: 2 -> 1 -> 0 -> 0 -> 0
    applyStimulus(1, 0, 32'h60, 0, 32'h0, 0, 0);
    tick();
    checkOutput("nt1_ctr", dut.pht_q[24], 1);
    tick();
    checkOutput("nt2_ctr", dut.pht_q[24], 0);
    tick();
    tick();
    checkOutput("nt_sat_ctr", dut.pht_q[24], 0);
    applyStimulus(0, 0, 0, 0, 0, 0, 0);
    #1;
    checkOutput("nt_is_branch", is_branch, 1);
    checkOutput("nt_pred", pht_prediction, 0);
    checkOutput("nt_pc_taken", pc_taken, 32'h64);

    applyStimulus(1, 0, 32'h60, 1, 32'h100, 0, 0);
    tick();
    applyStimulus(0, 0, 0, 0, 0, 0, 0);
    #1;
    checkOutput("t1_ctr", dut.pht_q[24], 1);
    checkOutput("t1_pred", pht_prediction, 0);

    // Saturate upward: 1 -> 2 -> 3 -> 3
    applyStimulus(1, 0, 32'h60, 1, 32'h100, 0, 0);
    tick();
    tick();
    tick();
    applyStimulus(0, 0, 0, 0, 0, 0, 0);
    #1;
    checkOutput("sat_hi_ctr", dut.pht_q[24], 3);
    checkOutput("sat_hi_pred", pht_prediction, 1);

    // Jump at 0x80 predicted taken without PHT training or history shift
    applyStimulus(1, 1, 32'h80, 1, 32'h200, 0, 0);
    tick();
    applyStimulus(0, 0, 0, 0, 0, 0, 0);
    fetch_pc = 32'h80;
    #1;
    checkOutput("jmp_is_branch", is_branch, 1);
    checkOutput("jmp_pred", pht_prediction, 1);
    checkOutput("jmp_pc_taken", pc_taken, 32'h200);
    checkOutput("jmp_pht_untouched", dut.pht_q[32], 1);
    fetch_advance = 1'b1;
    tick();
    fetch_advance = 1'b0;
    #1;
    checkOutput("jmp_no_shift", pred_ghr, 0);

    // Speculative shift on a predicted-taken conditional branch
    fetch_pc = 32'h60;
    fetch_advance = 1'b1;
    tick();
    fetch_advance = 1'b0;
    #1;
    checkOutput("spec_ghr", pred_ghr, 7'h01);
    checkOutput("gshare_pred", pht_prediction, 0);
    checkOutput("gshare_pc_taken", pc_taken, 32'h64);

    // Recovery loads GHR; then recovery wins over a same-cycle speculative shift
    applyStimulus(0, 1, 0, 0, 0, 7'h55, 1);
    tick();
    applyStimulus(0, 0, 0, 0, 0, 0, 0);
    #1;
    checkOutput("rec_jump_ghr", pred_ghr, 7'h55);
    fetch_advance = 1'b1;
    applyStimulus(0, 0, 0, 1, 0, 7'h12, 1);
    #1;
    checkOutput("rec_spec_hit", is_branch, 1);
    tick();
    fetch_advance = 1'b0;
    applyStimulus(0, 0, 0, 0, 0, 0, 0);
    #1;
    checkOutput("rec_prio_ghr", pred_ghr, 7'h25);

    // BTB conflict: 0xE0 shares index with 0x60 and evicts it
    applyStimulus(1, 0, 32'hE0, 1, 32'h300, 0, 0);
    tick();
    applyStimulus(0, 0, 0, 0, 0, 0, 0);
    #1;
    checkOutput("conf_old_miss", is_branch, 0);
    checkOutput("conf_old_pc", pc_taken, 32'h64);
    checkOutput("conf_ctr", dut.pht_q[56], 2);
    fetch_pc = 32'hE0;
    #1;
    checkOutput("conf_new_hit", is_branch, 1);

    // Not-taken miss trains the PHT but does not allocate in the BTB
    applyStimulus(1, 0, 32'h400, 0, 32'h500, 0, 0);
    tick();
    applyStimulus(0, 0, 0, 0, 0, 0, 0);
    fetch_pc = 32'h400;
    #1;
    checkOutput("ntmiss_no_alloc", is_branch, 0);
    checkOutput("ntmiss_ctr", dut.pht_q[0], 0);

    // Performance counters
    perf_pred = 1'b1;
    perf_mispred = 1'b1;
    repeat (3) tick();
    perf_mispred = 1'b0;
    repeat (7) tick();
    perf_pred = 1'b0;
    #1;
    checkOutput("perf_pred_10", perf_pred_count, 10);
    checkOutput("perf_mispred_3", perf_mispred_count, 3);
    force dut.perf_pred_count_q = 32'hFFFF_FFFF;
    #1;
    release dut.perf_pred_count_q;
    perf_pred = 1'b1;
    #1;
    checkOutput("perf_preload", perf_pred_count, 32'hFFFF_FFFF);
    tick();
    perf_pred = 1'b0;
    #1;
    checkOutput("perf_wrap", perf_pred_count, 0);
    checkOutput("perf_mispred_hold", perf_mispred_count, 3);

    // Asynchronous reset mid-run, with an update pending that must be dropped
    fetch_pc = 32'h80;
    #1;
    checkOutput("pre_rst_hit", is_branch, 1);
    #1;
    rst_n = 1'b0;
    #1;
    checkOutput("arst_is_branch", is_branch, 0);
    checkOutput("arst_pc_taken", pc_taken, 32'h84);
    checkOutput("arst_ghr", pred_ghr, 0);
    checkOutput("arst_perf_mispred", perf_mispred_count, 0);
    checkOutput("arst_ctr", dut.pht_q[24], 1);
    applyStimulus(1, 0, 32'h60, 1, 32'h100, 0, 0);
    tick();
    applyStimulus(0, 0, 0, 0, 0, 0, 0);
    rst_n = 1'b1;
    fetch_pc = 32'h60;
    #1;
    checkOutput("arst_drop_upd", is_branch, 0);

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule

// File: doc/branch_predictor.md
# branch_predictor

Fetch-side branch predictor that closes the loop with the execute stage. Each cycle it looks up the fetch PC in a direct-mapped branch target buffer (BTB) and a gshare pattern history table (PHT) of 2-bit counters, then produces `is_branch`, `pht_prediction` and `pc_taken` for IF. When a branch or jump resolves in EX, it takes the actual outcome and target back to train the tables and to repair the speculative global history. It also keeps the prediction/misprediction performance counters.

## Interface
Parameters:
- `PHT_IDX_BITS`, 7: PHT has 2^7 entries; this is also the global history register (GHR) width.
- `BTB_IDX_BITS`, 5: BTB has 2^5 entries; tag = pc[31:BTB_IDX_BITS+2].

Ports:
- `clk` in 1: the single clock.
- `rst_n` in 1: reset, asynchronous and active-low.
- `fetch_pc` in 32: PC being fetched.
- `fetch_advance` in 1: IF→ID register loads this cycle (not stalled).
- `is_branch` out 1: BTB hit on fetch_pc.
- `pht_prediction` out 1: predicted taken (forced 1 for jumps).
- `pc_taken` out 32: predicted next PC, either BTB target or fetch_pc+4.
- `pred_ghr` out PHT_IDX_BITS: GHR snapshot; travels down the pipe with the instruction.
- `upd_valid` in 1: EX holds a resolved branch or jump (pipeline is_branch OR control branch/jump bit).
- `upd_is_jump` in 1: resolved instruction is an unconditional jump.
- `upd_pc` in 32: source_pc from EX.
- `upd_taken` in 1: branch_flag from EX.
- `upd_target` in 32: resolved target (pc_branch_target_in path, pre-mux).
- `upd_ghr` in PHT_IDX_BITS: snapshot returned from EX.
- `branch_recovery` in 1: EX misprediction redirect.
- `perf_pred` in 1, `perf_mispred` in 1: performance strobes from EX.
- `perf_pred_count` out 32, `perf_mispred_count` out 32.

## Operation
- Lookup is combinational with zero latency.
  - BTB index = fetch_pc[BTB_IDX_BITS+1:2]; hit = valid && tag match.
  - PHT index = fetch_pc[PHT_IDX_BITS+1:2] XOR GHR.
  - pht_prediction = hit && (is_jump_bit || counter[1]).
  - pc_taken = pht_prediction ? btb_target : fetch_pc+4.
  - pred_ghr = current GHR.
- Speculative history: when fetch_advance && hit && !is_jump_bit, GHR <= {GHR[N-2:0], counter[1]}.
- Training, when upd_valid:
  - PHT index = upd_pc[PHT_IDX_BITS+1:2] XOR upd_ghr. For conditional branches the counter saturates up on taken and down on not-taken, within 0..3. Jumps do not touch the PHT.
  - BTB: if upd_taken, write valid=1, tag, target=upd_target, is_jump=upd_is_jump. A not-taken branch that misses is not allocated; a hit entry is left as-is.
- Recovery: when branch_recovery, GHR <= upd_is_jump ? upd_ghr : {upd_ghr[N-2:0], upd_taken}. This has priority over any speculative shift in the same cycle.
- Performance counters: each increments by 1 per cycle its strobe is high and wraps modulo 2^32.

## Timing
- Reset values:
  - All BTB valid bits 0.
  - All PHT counters 2'b01 (weakly not-taken).
  - GHR 0.
  - Both performance counters 0.
  - Outputs right after reset: is_branch=0, pht_prediction=0, pc_taken=fetch_pc+4, pred_ghr=0.
- Reset asserted mid-operation clears state immediately. Pending updates are dropped.
- Table writes land at the rising edge and are visible to lookup in the next cycle.
- Same-cycle update and lookup to the same entry: the lookup sees the old value (read-before-write).
- Stall (fetch_advance=0): no GHR change; outputs track fetch_pc combinationally.
- Counter saturation: 3 stays 3 on taken, 0 stays 0 on not-taken.
- BTB conflict: a new taken branch overwrites the entry at its index regardless of the old tag.

## Structure
- Shared package `rv32i_types` gains:
  - `btb_entry_t` struct: valid, tag, target, is_jump.
  - constants `PHT_WEAK_NT = 2'b01` and `PC_ALIGN_BITS = 2`.
- One sub-module: `sat_counter2`, a pure next-state function for the 2-bit counter (inc/dec with saturation), instantiated in the update path.
- Storage is in flip-flops so the async reset can clear it; no SRAM macro.

## Test plan
- Reset, then fetch_pc=0x60 → is_branch=0, pht_prediction=0, pc_taken=0x64, both perf counters 0.
- Taken branch resolves (upd_pc=0x60, upd_target=0x100, upd_ghr=0), then fetch 0x60 next cycle with GHR 0 → is_branch=1, counter=2, pht_prediction=1, pc_taken=0x100.
- Four not-taken updates on the same index → counter goes 2→1→0→0 and prediction=0; one taken update → counter 1, still predicts not-taken.
- Jump update (upd_is_jump=1, target 0x200) → next fetch predicts taken to 0x200 with PHT unchanged, and the GHR does not shift on advance.
- GHR=0x55, upd_ghr=0x12, branch_recovery=1, upd_taken=1, with a speculative shift in the same cycle → GHR=0x25.
- Drive perf_pred for 10 cycles and perf_mispred for 3; preload perf_pred_count to 0xFFFFFFFF → counts match, then wrap to 0; assert rst_n low mid-run → all state clears asynchronously.
